// File: rtl/ours_xm_to_jtag_scan_engine_if.sv
// Request/response and JTAG pin bundle for the XM JTAG scan engine.
// Latency: n/a (wiring only).
// Backpressure: req_vld_i/req_rdy_o on the request side, rsp_vld_o/rsp_rdy_i on the response side.
//
// Ports (engine view, modport slave):
//   req_vld_i/req_rdy_o, mode_i, ir_i, dr_i, dr_len_i  request
//   rsp_vld_o/rsp_rdy_i, rsp_err_o, ir_o, dr_o          response with captured TDO bits
//   tck_o, tms_o, tdi_o, tdo_i                          JTAG pins
interface ours_xm_to_jtag_scan_engine_if #(
    parameter int IR_W     = 4,
    parameter int DR_MAX_W = 128,
    parameter int LEN_W    = $clog2(DR_MAX_W + 1)
);
    logic                req_vld_i;
    logic                req_rdy_o;
    logic [1:0]          mode_i;
    logic [IR_W-1:0]     ir_i;
    logic [DR_MAX_W-1:0] dr_i;
    logic [LEN_W-1:0]    dr_len_i;
    logic                rsp_vld_o;
    logic                rsp_rdy_i;
    logic                rsp_err_o;
    logic [IR_W-1:0]     ir_o;
    logic [DR_MAX_W-1:0] dr_o;
    logic                tck_o;
    logic                tms_o;
    logic                tdi_o;
    logic                tdo_i;

    modport slave (
        input  req_vld_i, mode_i, ir_i, dr_i, dr_len_i, rsp_rdy_i, tdo_i,
        output req_rdy_o, rsp_vld_o, rsp_err_o, ir_o, dr_o, tck_o, tms_o, tdi_o
    );

    modport master (
        output req_vld_i, mode_i, ir_i, dr_i, dr_len_i, rsp_rdy_i, tdo_i,
        input  req_rdy_o, rsp_vld_o, rsp_err_o, ir_o, dr_o, tck_o, tms_o, tdi_o
    );
endinterface

// File: rtl/ours_xm_to_jtag_scan_engine.sv
// Turns one request (TAP reset / IR / DR / IR+DR) into a TCK/TMS/TDI stream and returns captured TDO bits.
// Latency: response valid steps*2*CLK_DIV cycles after accept; rejected requests respond on the accept edge.
// Backpressure: one request in flight; req_rdy_o only in IDLE, response held in RSP until rsp_rdy_i.
//
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport) carries the request,
// the response (rsp_err_o, ir_o, dr_o) and the registered JTAG pins tck_o/tms_o/tdi_o plus tdo_i.
module ours_xm_to_jtag_scan_engine #(
    parameter int IR_W     = 4,
    parameter int DR_MAX_W = 128,
    parameter int CLK_DIV  = 1,
    parameter int LEN_W    = $clog2(DR_MAX_W + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    ours_xm_to_jtag_scan_engine_if.slave    bus
);
    localparam int STEP_W = $clog2(IR_W + DR_MAX_W + 12);
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int IRI_W  = (IR_W > 1) ? $clog2(IR_W) : 1;
    localparam int DRI_W  = (DR_MAX_W > 1) ? $clog2(DR_MAX_W) : 1;

    // Shift-IR always occupies steps 5..5+IR_W-1; Shift-DR starts at 4 (DR only) or after the IR field.
    localparam logic [STEP_W-1:0] IR_LO      = STEP_W'(5);
    localparam logic [STEP_W-1:0] IR_HI      = STEP_W'(5 + IR_W);
    localparam logic [STEP_W-1:0] DR_LO_DR   = STEP_W'(4);
    localparam logic [STEP_W-1:0] DR_LO_IRDR = STEP_W'(IR_W + 9);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RSP} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_mode;
    logic [IR_W-1:0]     r_ir, r_ir_cap;
    logic [DR_MAX_W-1:0] r_dr, r_dr_cap;
    logic [LEN_W-1:0]    r_len;
    logic [STEP_W-1:0]   r_step, r_last;
    logic [DIV_W-1:0]    r_div;
    logic                r_tck, r_tms, r_tdi, r_err;

    logic                w_accept, w_bad, w_phase_end, w_step_end, w_last_step;
    logic [STEP_W-1:0]   w_dr_lo, w_dr_hi, w_nxt;
    logic                w_cir, w_cdr, w_nir, w_ndr, w_tms_nxt, w_tdi_nxt;
    logic [IRI_W-1:0]    w_cir_idx, w_nir_idx;
    logic [DRI_W-1:0]    w_cdr_idx, w_ndr_idx;

    function automatic logic in_ir(input logic [STEP_W-1:0] s, input logic en);
        return en && (s >= IR_LO) && (s < IR_HI);
    endfunction

    function automatic logic in_dr(input logic [STEP_W-1:0] s, input logic [STEP_W-1:0] lo,
                                   input logic [STEP_W-1:0] hi, input logic en);
        return en && (s >= lo) && (s < hi);
    endfunction

    assign bus.req_rdy_o = (r_state == S_IDLE) && rst_n;
    assign bus.rsp_vld_o = (r_state == S_RSP);
    assign bus.rsp_err_o = r_err;
    assign bus.ir_o      = r_ir_cap;
    assign bus.dr_o      = r_dr_cap;
    assign bus.tck_o     = r_tck;
    assign bus.tms_o     = r_tms;
    assign bus.tdi_o     = r_tdi;

    assign w_accept    = bus.req_vld_i && bus.req_rdy_o;
    assign w_bad       = bus.mode_i[1] && ((bus.dr_len_i == '0) || (bus.dr_len_i > LEN_W'(DR_MAX_W)));
    assign w_phase_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_step_end  = w_phase_end && r_tck;
    assign w_last_step = (r_step == r_last);

    assign w_dr_lo = (r_mode == 2'b10) ? DR_LO_DR : DR_LO_IRDR;
    assign w_dr_hi = w_dr_lo + STEP_W'(r_len);
    assign w_nxt   = r_step + STEP_W'(1);

    // Current step decides where TDO lands; next step decides the TMS/TDI launched at the falling edge.
    assign w_cir     = in_ir(r_step, r_mode[0]);
    assign w_cdr     = in_dr(r_step, w_dr_lo, w_dr_hi, r_mode[1]);
    assign w_cir_idx = IRI_W'(r_step - IR_LO);
    assign w_cdr_idx = DRI_W'(r_step - w_dr_lo);
    assign w_nir     = in_ir(w_nxt, r_mode[0]);
    assign w_ndr     = in_dr(w_nxt, w_dr_lo, w_dr_hi, r_mode[1]);
    assign w_nir_idx = IRI_W'(w_nxt - IR_LO);
    assign w_ndr_idx = DRI_W'(w_nxt - w_dr_lo);

    // TMS is 1 at: Select-DR (step 1), Select-IR (step 2 for IR modes), the last bit of each
    // shift field (Exit1), Update before the final idle step, and the IR->DR hop in mode 11.
    assign w_tms_nxt = (r_mode == 2'b00) ? (w_nxt < STEP_W'(5)) :
                       ((w_nxt == STEP_W'(1)) ||
                        (r_mode[0] && (w_nxt == STEP_W'(2))) ||
                        (w_nir && (w_nxt == IR_HI - STEP_W'(1))) ||
                        (w_ndr && (w_nxt == w_dr_hi - STEP_W'(1))) ||
                        (w_nxt == r_last - STEP_W'(1)) ||
                        ((r_mode == 2'b11) && ((w_nxt == IR_HI) || (w_nxt == IR_HI + STEP_W'(1)))));
    assign w_tdi_nxt = w_nir ? r_ir[w_nir_idx] : (w_ndr ? r_dr[w_ndr_idx] : 1'b0);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_bad ? S_RSP : S_RUN;
            S_RUN:   if (w_step_end && w_last_step) w_state_nxt = S_RSP;
            S_RSP:   if (bus.rsp_rdy_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode   <= '0;
            r_ir     <= '0;
            r_dr     <= '0;
            r_len    <= '0;
            r_step   <= '0;
            r_last   <= '0;
            r_div    <= '0;
            r_tck    <= 1'b0;
            r_tms    <= 1'b0;
            r_tdi    <= 1'b0;
            r_err    <= 1'b0;
            r_ir_cap <= '0;
            r_dr_cap <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode   <= bus.mode_i;
                        r_ir     <= bus.ir_i;
                        r_dr     <= bus.dr_i;
                        r_len    <= bus.dr_len_i;
                        r_err    <= w_bad;
                        r_ir_cap <= '0;
                        r_dr_cap <= '0;
                        r_step   <= '0;
                        r_div    <= '0;
                        r_tck    <= 1'b0;
                        // Step 0 is never a shift step; only TAP reset starts with TMS=1.
                        r_tms    <= !w_bad && (bus.mode_i == 2'b00);
                        r_tdi    <= 1'b0;
                        case (bus.mode_i)
                            2'b00:   r_last <= STEP_W'(5);
                            2'b01:   r_last <= STEP_W'(IR_W + 6);
                            2'b10:   r_last <= STEP_W'(bus.dr_len_i) + STEP_W'(5);
                            default: r_last <= STEP_W'(bus.dr_len_i) + STEP_W'(IR_W + 10);
                        endcase
                    end
                end
                S_RUN: begin
                    if (!w_phase_end) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_tck) begin
                            r_tck <= 1'b1;
                            if (w_cir) r_ir_cap[w_cir_idx] <= bus.tdo_i;
                            if (w_cdr) r_dr_cap[w_cdr_idx] <= bus.tdo_i;
                        end else begin
                            r_tck <= 1'b0;
                            if (w_last_step) begin
                                r_tms <= 1'b0;
                                r_tdi <= 1'b0;
                            end else begin
                                r_step <= w_nxt;
                                r_tms  <= w_tms_nxt;
                                r_tdi  <= w_tdi_nxt;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ours_xm_to_jtag_scan_engine.sv
// Bench for ours_xm_to_jtag_scan_engine: two instances (CLK_DIV=1 and CLK_DIV=3) with TDO looped back
// from TDI, checked against a per-step TMS/TDI model built from the TAP walk of each request mode.
module tb_ours_xm_to_jtag_scan_engine;
    localparam int IR_W     = 4;
    localparam int DR_MAX_W = 128;
    localparam int LEN_W    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                req_vld = 1'b0;
    logic                sel     = 1'b0;
    logic                rsp_rdy = 1'b1;
    logic [1:0]          mode_in = '0;
    logic [IR_W-1:0]     ir_in   = '0;
    logic [DR_MAX_W-1:0] dr_in   = '0;
    logic [LEN_W-1:0]    len_in  = '0;

    ours_xm_to_jtag_scan_engine_if #(.IR_W(IR_W), .DR_MAX_W(DR_MAX_W), .LEN_W(LEN_W)) if1 ();
    ours_xm_to_jtag_scan_engine_if #(.IR_W(IR_W), .DR_MAX_W(DR_MAX_W), .LEN_W(LEN_W)) if3 ();

    ours_xm_to_jtag_scan_engine #(.IR_W(IR_W), .DR_MAX_W(DR_MAX_W), .CLK_DIV(1), .LEN_W(LEN_W))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    ours_xm_to_jtag_scan_engine #(.IR_W(IR_W), .DR_MAX_W(DR_MAX_W), .CLK_DIV(3), .LEN_W(LEN_W))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if1.req_vld_i = req_vld & ~sel;
    assign if3.req_vld_i = req_vld & sel;
    assign if1.mode_i = mode_in;   assign if3.mode_i = mode_in;
    assign if1.ir_i = ir_in;       assign if3.ir_i = ir_in;
    assign if1.dr_i = dr_in;       assign if3.dr_i = dr_in;
    assign if1.dr_len_i = len_in;  assign if3.dr_len_i = len_in;
    assign if1.rsp_rdy_i = rsp_rdy; assign if3.rsp_rdy_i = rsp_rdy;

    // Loopback flop: TDI launched at the TCK-falling clk edge reappears on TDO before TCK rises.
    logic loop1 = 1'b0, loop3 = 1'b0;
    always @(negedge clk) begin
        loop1 <= if1.tdi_o;
        loop3 <= if3.tdi_o;
    end
    assign if1.tdo_i = loop1;
    assign if3.tdo_i = loop3;

    logic                o_rdy, o_vld, o_err, o_tck, o_tms, o_tdi;
    logic [IR_W-1:0]     o_ir;
    logic [DR_MAX_W-1:0] o_dr;
    always_comb begin
        if (sel) begin
            o_rdy = if3.req_rdy_o; o_vld = if3.rsp_vld_o; o_err = if3.rsp_err_o;
            o_tck = if3.tck_o; o_tms = if3.tms_o; o_tdi = if3.tdi_o; o_ir = if3.ir_o; o_dr = if3.dr_o;
        end else begin
            o_rdy = if1.req_rdy_o; o_vld = if1.rsp_vld_o; o_err = if1.rsp_err_o;
            o_tck = if1.tck_o; o_tms = if1.tms_o; o_tdi = if1.tdi_o; o_ir = if1.ir_o; o_dr = if1.dr_o;
        end
    end

    // Pin monitor: sampled 2 time units after each rising clk edge.
    bit mq_tms[$];
    bit mq_tdi[$];
    int hi_runs[$];
    int lo_runs[$];
    int hi_len = 0, lo_len = 0;
    bit seen_hi = 1'b0, prev_tck = 1'b0;
    always @(posedge clk) begin
        #2;
        if (o_tck && !prev_tck) begin
            mq_tms.push_back(o_tms);
            mq_tdi.push_back(o_tdi);
            if (seen_hi) lo_runs.push_back(lo_len);
            hi_len = 1;
        end else if (o_tck) begin
            hi_len++;
        end else if (prev_tck) begin
            hi_runs.push_back(hi_len);
            seen_hi = 1'b1;
            lo_len  = 1;
        end else begin
            lo_len++;
        end
        prev_tck = o_tck;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state for the request in flight.
    logic [1:0]          cur_mode;
    logic [IR_W-1:0]     cur_ir;
    logic [DR_MAX_W-1:0] cur_dr;
    int                  cur_len, cur_div;
    bit                  cur_err;
    bit                  exp_tms[$];
    bit                  exp_tdi[$];
    logic [IR_W-1:0]     exp_ir;
    logic [DR_MAX_W-1:0] exp_dr;

    task automatic push_step(input bit t, input bit d);
        exp_tms.push_back(t);
        exp_tdi.push_back(d);
    endtask

    task automatic push_dr_field();
        for (int k = 0; k < cur_len; k++) begin
            push_step(k == cur_len - 1, cur_dr[k]);
            exp_dr[k] = cur_dr[k];
        end
    endtask

    task automatic build_exp();
        exp_tms.delete(); exp_tdi.delete();
        exp_ir = '0; exp_dr = '0;
        if (cur_err) return;
        if (cur_mode == 2'b00) begin
            for (int k = 0; k < 6; k++) push_step(k < 5, 1'b0);
        end else if (cur_mode == 2'b10) begin
            push_step(0, 0); push_step(1, 0); push_step(0, 0); push_step(0, 0);
            push_dr_field();
            push_step(1, 0); push_step(0, 0);
        end else begin
            push_step(0, 0); push_step(1, 0); push_step(1, 0); push_step(0, 0); push_step(0, 0);
            for (int k = 0; k < IR_W; k++) push_step(k == IR_W - 1, cur_ir[k]);
            exp_ir = cur_ir;
            if (cur_mode == 2'b11) begin
                push_step(1, 0); push_step(1, 0); push_step(0, 0); push_step(0, 0);
                push_dr_field();
            end
            push_step(1, 0); push_step(0, 0);
        end
    endtask

    task automatic start_req(input bit s, input logic [1:0] m, input logic [IR_W-1:0] i,
                             input logic [DR_MAX_W-1:0] d, input int l);
        sel = s;
        cur_div = s ? 3 : 1;
        cur_mode = m; cur_ir = i; cur_dr = d; cur_len = l;
        cur_err = m[1] && (l == 0 || l > DR_MAX_W);
        build_exp();
        mq_tms.delete(); mq_tdi.delete(); hi_runs.delete(); lo_runs.delete();
        seen_hi = 1'b0; hi_len = 0; lo_len = 0;
        mode_in = m; ir_in = i; dr_in = d; len_in = LEN_W'(l);
        req_vld = 1'b1;
        chk("req_rdy_idle", o_rdy, 1);
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
        chk("req_rdy_busy", o_rdy, 0);
    endtask

    task automatic wait_check();
        int lat, steps, nbad;
        logic [255:0] ov, ev;
        lat = 0;
        while (o_vld !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        steps = exp_tms.size();
        chk("rsp_latency", lat, cur_err ? 0 : steps * 2 * cur_div);
        chk("rsp_err", o_err, cur_err);
        chk("tck_at_rsp", o_tck, 0);
        chk("tms_at_rsp", o_tms, 0);
        chk("ir_o", o_ir, exp_ir);
        chk("dr_o", o_dr, exp_dr);
        chk("tck_rises", mq_tms.size(), steps);
        chk("tck_highs", hi_runs.size(), steps);
        ov = '0; ev = '0;
        for (int k = 0; k < mq_tms.size() && k < 256; k++) ov[k] = mq_tms[k];
        for (int k = 0; k < steps && k < 256; k++) ev[k] = exp_tms[k];
        chk("tms_trace", ov, ev);
        ov = '0; ev = '0;
        for (int k = 0; k < mq_tdi.size() && k < 256; k++) ov[k] = mq_tdi[k];
        for (int k = 0; k < steps && k < 256; k++) ev[k] = exp_tdi[k];
        chk("tdi_trace", ov, ev);
        nbad = 0;
        foreach (hi_runs[k]) if (hi_runs[k] != cur_div) nbad++;
        foreach (lo_runs[k]) if (lo_runs[k] != cur_div) nbad++;
        chk("tck_duty", nbad, 0);
    endtask

    task automatic finish_hs();
        @(negedge clk);
        chk("rsp_vld_drop", o_vld, 0);
        chk("req_rdy_back", o_rdy, 1);
    endtask

    task automatic do_req(input bit s, input logic [1:0] m, input logic [IR_W-1:0] i,
                          input logic [DR_MAX_W-1:0] d, input int l);
        start_req(s, m, i, d, l);
        wait_check();
        finish_hs();
    endtask

    function automatic logic [DR_MAX_W-1:0] rand_dr();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [IR_W-1:0] ir_a;
        int nv, n, l;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", o_rdy, 0);
        chk("rst_vld", o_vld, 0);
        chk("rst_err", o_err, 0);
        chk("rst_tck", o_tck, 0);
        chk("rst_tms", o_tms, 0);
        chk("rst_tdi", o_tdi, 0);
        chk("rst_ir", o_ir, 0);
        chk("rst_dr", o_dr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", o_rdy, 1);

        do_req(0, 2'b11, 4'hA, 128'hA5, 8);
        do_req(1, 2'b10, 4'h0, rand_dr(), 128);
        do_req(0, 2'b00, 4'h0, '0, 0);
        do_req(0, 2'b10, 4'h3, rand_dr(), 0);
        do_req(0, 2'b10, 4'h3, rand_dr(), DR_MAX_W + 1);
        do_req(1, 2'b11, 4'h5, rand_dr(), 0);

        // Response stalled while a second request waits on the request port.
        rsp_rdy = 1'b0;
        ir_a = IR_W'($urandom);
        start_req(0, 2'b01, ir_a, '0, 0);
        mode_in = 2'b00; ir_in = ~ir_a; req_vld = 1'b1;
        wait_check();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_rdy", o_rdy, 0);
            chk("stall_vld", o_vld, 1);
            chk("stall_ir", o_ir, ir_a);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("hs_vld", o_vld, 0);
        chk("hs_rdy", o_rdy, 1);
        start_req(0, 2'b00, ~ir_a, '0, 0);
        wait_check();
        finish_hs();

        // Reset in the middle of an IR+DR scan.
        start_req(0, 2'b11, IR_W'($urandom), rand_dr(), 20);
        n = 0;
        while (mq_tms.size() < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_step9", mq_tms.size() >= 10, 1);
        rst_n = 1'b0;
        nv = 0;
        @(negedge clk);
        chk("abort_rdy", o_rdy, 0);
        chk("abort_vld", o_vld, 0);
        chk("abort_tck", o_tck, 0);
        chk("abort_tms", o_tms, 0);
        chk("abort_tdi", o_tdi, 0);
        chk("abort_ir", o_ir, 0);
        chk("abort_dr", o_dr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_vld !== 1'b0) nv++;
        end
        chk("abort_no_rsp", nv, 0);
        chk("abort_rdy_back", o_rdy, 1);
        do_req(0, 2'b11, IR_W'($urandom), rand_dr(), 33);

        // Randomised requests on both engines.
        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(0, 9);
            if (n == 0)      l = 0;
            else if (n == 1) l = DR_MAX_W + 1;
            else             l = $urandom_range(1, DR_MAX_W);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), IR_W'($urandom), rand_dr(), l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ours_xm_to_jtag_scan_engine.md
# ours_xm_to_jtag_scan_engine

Parametrised JTAG scan engine that converts one request (TAP mode, instruction, variable-length data) into a TCK/TMS/TDI bit stream and returns the TDO bits captured during the IR and DR shifts. It drives a DUT TAP directly and generates its own divided TCK. It supports IR-only, DR-only, IR+DR and TAP-reset requests, with valid/ready handshakes on both the request and the response side. It sits between the XM debug command decoder and the chip JTAG pins.

## Interface
- IR_W, 4: instruction register length in bits (≥2).
- DR_MAX_W, 128: maximum DR scan length in bits.
- CLK_DIV, 1: TCK half-period in clk cycles (≥1).
- LEN_W, $clog2(DR_MAX_W+1): width of dr_len_i (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_vld_i  in  1  request valid.
- req_rdy_o  out  1  request ready.
- mode_i  in  2  request type: 00 TAP reset, 01 IR only, 10 DR only, 11 IR then DR.
- ir_i  in  IR_W  instruction, shifted LSB first.
- dr_i  in  DR_MAX_W  data, shifted LSB first.
- dr_len_i  in  LEN_W  number of valid DR bits.
- rsp_vld_o  out  1  response valid.
- rsp_rdy_i  in  1  response accepted.
- rsp_err_o  out  1  request rejected; no TAP activity occurred.
- ir_o  out  IR_W  TDO bits captured during Shift-IR.
- dr_o  out  DR_MAX_W  TDO bits captured during Shift-DR; bits at index ≥ dr_len are 0.
- tck_o, tms_o, tdi_o  out  1 each  JTAG drive, all registered.
- tdo_i  in  1  JTAG return.

## Operation
- The FSM has three states: IDLE, RUN, RSP.
- req_rdy_o = (state==IDLE) && rst_n. A request is accepted on the edge where req_vld_i && req_rdy_o. mode_i, ir_i, dr_i and dr_len_i are latched on that edge.
- Error check on accept: if the mode uses DR (10 or 11) and dr_len_i is 0 or greater than DR_MAX_W, go IDLE→RSP with rsp_err_o=1, ir_o=0 and dr_o=0. No TCK edges are generated.
- Otherwise go IDLE→RUN. Each TAP step sets TMS/TDI and then completes one TCK cycle. The TMS sequence per mode, starting and ending in Run-Test/Idle, is:
  - 00: 1,1,1,1,1,0 (6 steps).
  - 01: 0,1,1,0,0; IR_W shift bits (last bit TMS=1); 1,0. Total IR_W+7 steps.
  - 10: 0,1,0,0; dr_len shift bits (last bit TMS=1); 1,0. Total dr_len+6 steps.
  - 11: 0,1,1,0,0; IR_W bits (last TMS=1); 1,1,0,0; dr_len bits (last TMS=1); 1,0. Total IR_W+dr_len+11 steps.
- TDI carries ir/dr bit k on the k-th shift step of the corresponding field and is 0 on every other step.
- TDO sampled on shift step k is written to ir_o[k] or dr_o[k]. The capture registers are cleared on accept.
- RUN→RSP after the high phase of the last step. RSP→IDLE on rsp_vld_o && rsp_rdy_i.
- rsp_vld_o = (state==RSP). ir_o, dr_o and rsp_err_o are held stable while in RSP.
- Requests presented while req_rdy_o=0 are ignored and not queued.

## Timing
- Reset values: req_rdy_o 0 while rst_n=0 and 1 after; rsp_vld_o 0, rsp_err_o 0, ir_o 0, dr_o 0, tck_o 0, tms_o 0, tdi_o 0; state IDLE.
- Step timing: tck_o is low for CLK_DIV cycles, then high for CLK_DIV cycles. tms_o/tdi_o update on the same edge that drives tck_o low. tdo_i is sampled on the edge that drives tck_o high.
- Accept at edge E0:
  - Step 0 low phase begins at E0.
  - rsp_vld_o rises at E0 + steps·2·CLK_DIV, with tck_o=0 and tms_o=0 from that edge.
  - Error path: rsp_vld_o rises at E0.
- Back-to-back: the earliest next accept is the edge after the response handshake, since req_rdy_o=1 only in IDLE.
- Reset mid-RUN: the next edge aborts the scan, forces the reset values, and produces no response. The TAP state is then undefined; software must issue mode 00.
- Counters:
  - Step counter width is $clog2(IR_W+DR_MAX_W+12).
  - Divider counter width is $clog2(CLK_DIV)+1.
  - Neither counter ever wraps within a legal request.

## Test plan
- IR_W=4, CLK_DIV=1, mode 11, ir=4'hA, dr_len=8, dr=8'hA5, tdo_i looped to tdi_o through a 1-bit TCK-falling register → ir_o=4'hA, dr_o=8'hA5. The bench also checks the TMS trace and that rsp_vld_o rises at E0+46.
- CLK_DIV=3, mode 10, dr_len=128, random dr, loopback → dr_o==dr and rsp_vld_o at E0+804. The bench also checks that the TCK duty cycle is 3/3.
- Mode 00 → TMS trace 1,1,1,1,1,0 with tdi_o=0 throughout; rsp_vld_o at E0+12.
- Mode 10 with dr_len=0 and then with dr_len=DR_MAX_W+1 → rsp_err_o=1, rsp_vld_o at E0, zero tck_o toggles.
- Mode 01 completes with rsp_rdy_i held low for 10 cycles while req_vld_i is held high → req_rdy_o stays 0, ir_o stays stable, and the second request is accepted on the cycle after the handshake.
- rst_n driven low at step 9 of a mode 11 scan → outputs at reset values on the next edge, no rsp_vld_o, and a subsequent request runs normally.
